imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, packs each group of four bytes little-endian into a 32-bit instruction, and writes the instruction to consecutive word addresses through the memory write port. While a load is in progress it holds `iready` low, so the fetch path reads zeros. It raises `iready` once the program image is complete.

## Interface
- `ROW`, 256: instruction memory depth in words. Must be a power of two, ≥ 4.
- `AW`, `$clog2(ROW)`: word address width. Derived; do not override.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle load request; honoured only in IDLE or DONE.
- `load_words`  in  AW+1  number of words to load; sampled when `start` is honoured.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write enable.
- `mem_waddr`  out  AW  word address (byte address >> 2).
- `mem_wdata`  out  32  instruction word.
- `iready`  out  1  image valid; drives the instruction memory read gate.
- `busy`  out  1  load in progress.
- `err`  out  1  last load failed; sticky until the next honoured `start` or `rst`.

## Operation
- States: IDLE, RECV, WRITE, CHECK (only with checksum), DONE.
- Reset forces IDLE with every output 0: `s_ready`, `mem_we`, `mem_waddr`, `mem_wdata`, `iready`, `busy`, `err`. The byte counter, word counter and checksum accumulator also clear.
- IDLE/DONE + `start`:
  - `load_words == 0`: go to DONE, `iready`=1.
  - `load_words > ROW`: go to DONE, `err`=1, `iready`=0, no writes.
  - Otherwise: latch the length, clear the counters, clear `err`, drop `iready`, go to RECV.
- RECV: `s_ready`=1. Each `s_valid && s_ready` stores the byte in lane `byte_cnt` (lane 0 = bits [7:0]). On the 4th byte, go to WRITE.
- WRITE: one cycle with `mem_we`=1, `mem_waddr`=word counter, `mem_wdata`=assembled word, `s_ready`=0. Then increment the word counter.
  - If words remain, return to RECV.
  - If none remain, go to DONE, or to RECV-for-checksum when the checksum is enabled.
- DONE: `iready`=1 unless `err`. `busy`=0.
- `busy`=1 in RECV, WRITE and CHECK.
- `start` while `busy` is ignored. The current load is unaffected.
- `start` in DONE restarts the load. `iready` falls on the cycle after `start`.
- Address arithmetic: `mem_waddr` is the AW-bit word counter. With `load_words == ROW`, the last write goes to ROW-1. The counter never wraps inside a load.
- `rst` mid-load: abandon immediately and return to IDLE. Partial writes stay in memory and `iready`=0.

## Timing
- All outputs are registered.
- A byte is accepted on the rising edge where `s_valid && s_ready`.
- Minimum 5 cycles per word: 4 RECV + 1 WRITE.
- The WRITE cycle for word N starts on the cycle after its 4th byte is accepted.
- `iready` rises on the cycle after the final WRITE, or after CHECK when the checksum is enabled.
- `s_ready` is 0 outside RECV, so bytes offered in other states are not consumed.
- `mem_we` is never high for two consecutive cycles.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Keep a running 32-bit modular sum of all written words.
  - After the last WRITE, receive 4 more bytes (little-endian) as the expected sum. These are not written to memory.
  - CHECK takes one cycle and compares: match → DONE with `iready`=1; mismatch → DONE with `err`=1, `iready`=0.
  - `load_words == 0` still goes straight to DONE, with no checksum bytes.
- Not defined: no accumulator and no CHECK state. Go to DONE directly after the last WRITE.

## Test plan
- Reset, then `start` with `load_words`=2 and bytes 13 00 00 00 93 00 10 00 (s_valid held high) → writes addr0=0x00000013, addr1=0x00100093. `iready` rises 1 cycle after the 2nd write; 10 cycles total.
- `load_words`=3 with `s_valid` toggling every other cycle → same words, no extra writes, `mem_we` only after each 4th accepted byte.
- `load_words`=0 → DONE next cycle, `iready`=1, no writes. `load_words`=257 with ROW=256 → `err`=1, `iready`=0, no writes.
- `load_words`=ROW → last write goes to `mem_waddr`=255 with no wrap. `start` pulsed mid-load is ignored. `rst` after 2 bytes → all outputs 0 next cycle.
- With `IMEM_LOADER_CHECKSUM_EN`: words 0x1, 0x2 followed by checksum 03 00 00 00 → `iready`=1. Checksum 04 00 00 00 → `err`=1, `iready`=0.
- Restart from DONE: `start` → `iready` falls next cycle and `err` clears. The new image overwrites from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a byte stream into little-endian words and writes them to consecutive addresses.
// Optional trailing checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ROW = 256,
    parameter int AW  = $clog2(ROW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   load_words,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          iready,
    output logic          busy,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    localparam logic [AW:0] ROW_W = (AW+1)'(ROW);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [AW:0] word_cnt;
    logic [AW:0] len;
    logic [23:0] lanes;
    logic [31:0] word_next;
    logic [AW:0] cnt_next;
    logic        accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;
    logic [31:0] exp_sum;
    logic        chk_phase;
`endif

    // The fourth byte is merged directly so the word is ready on the same edge it completes.
    assign word_next = {s_data, lanes};
    assign cnt_next  = word_cnt + 1'b1;
    assign accept    = s_valid && s_ready;

    // NOTE: non-blocking assignments only, so every register updates from its pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            len       <= '0;
            lanes     <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            iready    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
            exp_sum   <= '0;
            chk_phase <= 1'b0;
`endif
        end else begin
            // NOTE: mem_we defaults low every cycle, so a write strobe can never stretch to two cycles.
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (load_words == '0) begin
                            state  <= DONE;
                            iready <= 1'b1;
                            err    <= 1'b0;
                        end else if (load_words > ROW_W) begin
                            state  <= DONE;
                            iready <= 1'b0;
                            err    <= 1'b1;
                        end else begin
                            len      <= load_words;
                            byte_cnt <= '0;
                            word_cnt <= '0;
                            err      <= 1'b0;
                            iready   <= 1'b0;
                            busy     <= 1'b1;
                            s_ready  <= 1'b1;
                            state    <= RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            sum       <= '0;
                            chk_phase <= 1'b0;
`endif
                        end
                    end
                end

                RECV: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        case (byte_cnt)
                            2'd0:    lanes[7:0]   <= s_data;
                            2'd1:    lanes[15:8]  <= s_data;
                            2'd2:    lanes[23:16] <= s_data;
                            default: begin
                                s_ready <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                                if (chk_phase) begin
                                    exp_sum <= word_next;
                                    state   <= CHECK;
                                end else begin
                                    mem_we    <= 1'b1;
                                    mem_waddr <= word_cnt[AW-1:0];
                                    mem_wdata <= word_next;
                                    sum       <= sum + word_next;
                                    state     <= WRITE;
                                end
`else
                                mem_we    <= 1'b1;
                                mem_waddr <= word_cnt[AW-1:0];
                                mem_wdata <= word_next;
                                state     <= WRITE;
`endif
                            end
                        endcase
                    end
                end

                WRITE: begin
                    word_cnt <= cnt_next;
                    if (cnt_next < len) begin
                        s_ready <= 1'b1;
                        state   <= RECV;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_phase <= 1'b1;
                        s_ready   <= 1'b1;
                        state     <= RECV;
`else
                        busy   <= 1'b0;
                        iready <= 1'b1;
                        state  <= DONE;
`endif
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    busy  <= 1'b0;
                    state <= DONE;
                    if (sum == exp_sum) begin
                        iready <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: expected writes are derived from the byte image by plain packing arithmetic.
// Covers checksum scenarios too when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int ROW = 256;
    localparam int AW  = $clog2(ROW);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   load_words = '0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          iready;
    logic          busy;
    logic          err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] mon_e;
    logic           prev_we = 1'b0;

    imem_loader #(.ROW(ROW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_words (load_words),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .iready     (iready),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the next expected (address, word) pair.
    always @(negedge clk) begin
        if (mem_we) begin
            check("we_gap", 64'(prev_we), 64'd0);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("waddr", 64'(mem_waddr), 64'(mon_e[AW+31:32]));
                check("wdata", 64'(mem_wdata), 64'(mon_e[31:0]));
            end else begin
                check("spurious_we", 64'(mem_we), 64'd0);
            end
        end
        prev_we = mem_we;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_waddr"}, 64'(mem_waddr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_iready"}, 64'(iready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    function automatic byte_q_t rand_img(input int n);
        byte_q_t q;
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // mode: 0 = s_valid held high, 1 = toggling, 2 = random. spam_at: step at which a stray start is pulsed.
    task automatic run_load(input int n, input byte_q_t img, input int mode, input int spam_at,
                            input bit corrupt, input int exp_cycles);
        byte_q_t     stream;
        logic [31:0] sum;
        logic [31:0] w;
        int          t0;
        int          idx;
        int          step;
        int          k;
        bit          hit;
        stream = img;
        sum = '0;
        idx = 0;
        step = 0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            w = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
            sum += w;
            exp_q.push_back({AW'(i), w});
        end
        if (CHK) begin
            sum += 32'(corrupt);
            for (int b = 0; b < 4; b++) stream.push_back(sum[8*b +: 8]);
        end
        @(negedge clk);
        start = 1'b1;
        load_words = (AW+1)'(n);
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        check("start_busy", 64'(busy), 64'd1);
        check("start_iready", 64'(iready), 64'd0);
        check("start_err", 64'(err), 64'd0);
        while (idx < stream.size() && step < 20000) begin
            s_data = stream[idx];
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = step[0];
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            if (step == spam_at) begin
                start = 1'b1;
                load_words = (AW+1)'($urandom);
            end else begin
                start = 1'b0;
            end
            hit = s_valid && s_ready;
            @(posedge clk);
            if (hit) idx++;
            step++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        start = 1'b0;
        check("bytes_taken", 64'(idx), 64'(stream.size()));
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("finish_busy", 64'(busy), 64'd0);
        if (exp_cycles >= 0) check("cycles", 64'(cyc - t0), 64'(exp_cycles));
        check("done_iready", 64'(iready), 64'(!corrupt));
        check("done_err", 64'(err), 64'(corrupt));
        check("writes_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        byte_q_t img;
        int n;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Two-instruction image with s_valid held high.
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(2, img, 0, -1, 1'b0, CHK ? 15 : 10);

        // Restart from DONE: iready must fall right after start; toggling valid.
        run_load(3, rand_img(3), 1, -1, 1'b0, -1);

        // Empty image.
        @(negedge clk);
        start = 1'b1;
        load_words = '0;
        @(negedge clk);
        start = 1'b0;
        check("zero_iready", 64'(iready), 64'd1);
        check("zero_err", 64'(err), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_s_ready", 64'(s_ready), 64'd0);

        // Oversized image.
        @(negedge clk);
        start = 1'b1;
        load_words = (AW+1)'(ROW + 1);
        @(negedge clk);
        start = 1'b0;
        check("big_err", 64'(err), 64'd1);
        check("big_iready", 64'(iready), 64'd0);
        check("big_busy", 64'(busy), 64'd0);
        check("big_s_ready", 64'(s_ready), 64'd0);

        // Valid start clears the sticky error.
        run_load(1, rand_img(1), 2, -1, 1'b0, -1);

        // Full-depth image, random valid, stray start in the middle.
        run_load(ROW, rand_img(ROW), 2, 37, 1'b0, -1);

        // Reset after two bytes of a four-word load.
        @(negedge clk);
        start = 1'b1;
        load_words = (AW+1)'(4);
        @(negedge clk);
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 8'($urandom);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;

        // Assorted random loads.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 8);
            run_load(n, rand_img(n), $urandom_range(0, 2), $urandom_range(0, 10), 1'b0, -1);
        end

        if (CHK) begin
            img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
            run_load(2, img, 0, -1, 1'b0, 15);
            run_load(2, img, 0, -1, 1'b1, 15);
            run_load(3, rand_img(3), 2, -1, 1'b1, -1);
            run_load(3, rand_img(3), 2, -1, 1'b0, -1);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
